// File: rtl/led_bounce_pkg.sv
// led_bounce_pkg: shared types and helpers for the LED bounce sequencer.
//   state_e      - FSM state, encoded as the externally visible phase code
//   thermometer  - lit count -> bar pattern (bit i set when i < lvl)
//   LED_BOUNCE_CHECK_PARAMS(cond) - assertion on the parameter set
package led_bounce_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RISE1   = 3'd1,
    FALL1   = 3'd2,
    RISE2   = 3'd3,
    FALL2   = 3'd4,
    RISE3   = 3'd5,
    FALLEND = 3'd6
  } state_e;

  // Widest bar the thermometer helper can produce; callers cast down.
  localparam int THERM_MAX = 64;

  function automatic logic [THERM_MAX-1:0] thermometer(input int lvl);
    logic [THERM_MAX-1:0] t;
    for (int i = 0; i < THERM_MAX; i++) t[i] = (i < lvl);
    return t;
  endfunction

endpackage

`define LED_BOUNCE_CHECK_PARAMS(cond) assert (cond) else $error("led_bounce_seq: illegal parameter set")

// File: rtl/led_tick_gen.sv
// led_tick_gen: step-rate prescaler for the bounce sequencer.
//   clk, rst_n - clock, async active-low reset
//   hold       - freezes the counter and suppresses tick
//   tick       - high in the cycle the counter sits at TICK_DIV-1
module led_tick_gen #(
  parameter int TICK_DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic hold,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = ~hold & (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     cnt <= '0;
    else if (!hold) cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
  end

endmodule

// File: rtl/led_bounce_seq.sv
// led_bounce_seq: thermometer LED bar sequencer with three rise/fall phases.
//   clk, rst_n - clock, async active-low reset
//   flick      - start / kick request, rising-edge sensitive
//   hold       - freezes step timing
//   abort      - jumps a running sequence to the final fall
//   led        - thermometer bar of level
//   level      - lit LED count, 0..LED_W
//   phase      - state code
//   busy       - not idle
//   done       - one-cycle pulse on return to idle
module led_bounce_seq
  import led_bounce_pkg::*;
#(
  parameter int LED_W    = 16,
  parameter int A_PT     = 6,
  parameter int B_PT     = 11,
  parameter int C_PT     = 5,
  parameter int TICK_DIV = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flick,
  input  logic                       hold,
  input  logic                       abort,
  output logic [LED_W-1:0]           led,
  output logic [$clog2(LED_W+1)-1:0] level,
  output logic [2:0]                 phase,
  output logic                       busy,
  output logic                       done
);

  localparam int LW = $clog2(LED_W + 1);
  localparam logic [LW-1:0] ONE = LW'(1);
  localparam logic [LW-1:0] A_L = LW'(A_PT);
  localparam logic [LW-1:0] B_L = LW'(B_PT);
  localparam logic [LW-1:0] C_L = LW'(C_PT);
  localparam logic [LW-1:0] W_L = LW'(LED_W);

  state_e        state, state_n;
  logic [LW-1:0] lvl_n;
  logic          done_n;
  logic          flick_q, pend_q;
  logic          tick, flick_rise, pend, kick;

  led_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .hold (hold),
    .tick (tick)
  );

  // An edge in the tick cycle itself counts, so the pending view is the
  // latched request OR'd with the current edge.
  assign flick_rise = flick & ~flick_q;
  assign pend       = pend_q | flick_rise;
  assign kick       = pend & ((level == A_L) | (level == B_L));
  assign phase      = state;

  always_comb begin
    state_n = state;
    lvl_n   = level;
    done_n  = 1'b0;
    `LED_BOUNCE_CHECK_PARAMS(1 <= C_PT && C_PT < A_PT && A_PT < B_PT &&
                             B_PT < LED_W && TICK_DIV >= 1 && LED_W <= THERM_MAX);
    if (state > FALLEND) begin
      state_n = IDLE;
      lvl_n   = '0;
    end else if (abort) begin
      // Ignored in IDLE, which also suppresses a simultaneous start.
      if (state != IDLE) begin
        if (level == '0) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end else begin
          state_n = FALLEND;
        end
      end
    end else if (tick) begin
      case (state)
        IDLE:
          if (pend) begin state_n = RISE1; lvl_n = ONE; end
        RISE1:
          if (level == A_L) begin state_n = FALL1; lvl_n = level - ONE; end
          else lvl_n = level + ONE;
        FALL1:
          if (level == '0) begin state_n = RISE2; lvl_n = ONE; end
          else lvl_n = level - ONE;
        RISE2:
          if (kick || level == B_L) begin
            state_n = kick ? FALL1 : FALL2;
            lvl_n   = level - ONE;
          end else lvl_n = level + ONE;
        FALL2:
          if (level == C_L) begin state_n = RISE3; lvl_n = level + ONE; end
          else lvl_n = level - ONE;
        RISE3:
          if (kick || level == W_L) begin
            state_n = kick ? FALL2 : FALLEND;
            lvl_n   = level - ONE;
          end else lvl_n = level + ONE;
        FALLEND:
          if (level <= ONE) begin state_n = IDLE; lvl_n = '0; done_n = 1'b1; end
          else lvl_n = level - ONE;
        default: begin state_n = IDLE; lvl_n = '0; end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      level   <= '0;
      led     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      flick_q <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state   <= state_n;
      level   <= lvl_n;
      led     <= LED_W'(thermometer(int'(lvl_n)));
      busy    <= (state_n != IDLE);
      done    <= done_n;
      flick_q <= flick;
      // Consumed on every tick; abort also drops it so an aborted start
      // cannot fire later.
      if (tick || abort) pend_q <= 1'b0;
      else if (flick_rise) pend_q <= 1'b1;
    end
  end

endmodule
